// File: rtl/mem_load_store_unit_if.sv
// CPU request/response channel and memory data port for mem_load_store_unit.
// The slave modport is the load/store unit; the master modport is the CPU/memory side.
interface mem_load_store_unit_if #(
   parameter int AW = 8
);
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [1:0]    req_size;
   logic          req_signed;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic [AW-1:0] mem_addr_data;
   logic          mem_read_en_data;
   logic          mem_write_en_data;
   logic [31:0]   mem_read_val_data;
   logic [31:0]   mem_write_val_data;

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  mem_read_val_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_addr_data, mem_read_en_data, mem_write_en_data, mem_write_val_data
   );

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output mem_read_val_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_addr_data, mem_read_en_data, mem_write_en_data, mem_write_val_data
   );
endinterface

// File: rtl/mem_load_store_unit.sv
// Single-request load/store unit: byte/halfword/word access to a word-wide memory,
// big-endian lanes, sub-word stores done as read-modify-write.
module mem_load_store_unit #(
   parameter  int MEM_WIDTH = 32,
   parameter  int MEM_SIZE  = 256,
   localparam int AW        = $clog2(MEM_SIZE)
) (
   input logic                  clk,
   input logic                  reset,
   mem_load_store_unit_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] WR   = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [1:0]           state_q, state_d;
   logic                 write_q, write_d;
   logic [1:0]           size_q, size_d;
   logic                 signed_q, signed_d;
   logic [AW+1:0]        addr_q, addr_d;
   logic [15:0]          wdata_q, wdata_d;
   logic                 err_q, err_d;
   logic [MEM_WIDTH-1:0] word_q, word_d;
   logic [MEM_WIDTH-1:0] wval_q, wval_d;

   logic                 req_err;
   logic [31:0]          merged;
   logic [7:0]           lane_byte [4];
   logic [7:0]           byte_val;
   logic [15:0]          half_val;
   logic [31:0]          load_val;

   assign req_err = (bus.req_size == 2'b11)
                  || (bus.req_size == SZ_HALF && bus.req_addr[0])
                  || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
                  || (bus.req_addr >= 32'(MEM_SIZE * 4));

   // Lane 0 is the most significant byte; a halfword covers lanes {0,1} or {2,3}.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam int   HI       = 31 - 8 * gi;
      localparam int   WHI      = 15 - 8 * (gi % 2);
      localparam logic HALF_SEL = (gi >= 2);
      logic byte_hit, half_hit;
      assign byte_hit = (size_q == SZ_BYTE) && (addr_q[1:0] == 2'(gi));
      assign half_hit = (size_q == SZ_HALF) && (addr_q[1] == HALF_SEL);
      assign merged[HI -: 8] = byte_hit ? wdata_q[7:0] :
                               half_hit ? wdata_q[WHI -: 8] :
                                          bus.mem_read_val_data[HI -: 8];
      assign lane_byte[gi] = word_q[HI -: 8];
   end

   assign byte_val = lane_byte[addr_q[1:0]];
   assign half_val = addr_q[1] ? word_q[15:0] : word_q[31:16];

   always_comb begin
      load_val = word_q;
      case (size_q)
         SZ_BYTE: load_val = {{24{signed_q & byte_val[7]}}, byte_val};
         SZ_HALF: load_val = {{16{signed_q & half_val[15]}}, half_val};
         default: load_val = word_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      size_d   = size_q;
      signed_d = signed_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      word_d   = word_q;
      wval_d   = '0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               write_d  = bus.req_write;
               size_d   = bus.req_size;
               signed_d = bus.req_signed;
               addr_d   = bus.req_addr[AW+1:0];
               wdata_d  = bus.req_wdata[15:0];
               err_d    = req_err;
               if (req_err) begin
                  state_d = RESP;
               end else if (bus.req_write && bus.req_size == SZ_WORD) begin
                  state_d = WR;
                  wval_d  = bus.req_wdata;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            // The read word is captured here and also merged directly for a store.
            word_d = bus.mem_read_val_data;
            if (write_q) begin
               state_d = WR;
               wval_d  = merged;
            end else begin
               state_d = RESP;
            end
         end
         WR:      state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         word_q   <= '0;
         wval_q   <= '0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         word_q   <= word_d;
         wval_q   <= wval_d;
      end
   end

   assign bus.req_ready          = (state_q == IDLE);
   assign bus.resp_valid         = (state_q == RESP);
   assign bus.resp_err           = (state_q == RESP) && err_q;
   assign bus.resp_rdata         = (state_q == RESP && !err_q && !write_q) ? load_val : 32'h0;
   assign bus.mem_addr_data      = addr_q[AW+1:2];
   assign bus.mem_read_en_data   = (state_q == RD);
   assign bus.mem_write_en_data  = (state_q == WR);
   assign bus.mem_write_val_data = wval_q;
endmodule

// File: tb/tb_mem_load_store_unit.sv
// Directed bench for mem_load_store_unit: a transaction-level reference model predicts
// memory activity and responses, checked every cycle, plus literal spot checks.
module tb_mem_load_store_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic mem_clr = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_load_store_unit_if #(.AW(8)) bus ();

   mem_load_store_unit #(.MEM_WIDTH(32), .MEM_SIZE(256)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];

   assign bus.mem_read_val_data = mem[bus.mem_addr_data];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      end else if (bus.mem_write_en_data) begin
         mem[bus.mem_addr_data] <= bus.mem_write_val_data;
      end
   end

   typedef struct {
      int          acc_cyc;
      int          rd_cyc;
      int          wr_cyc;
      int          resp_cyc;
      logic [7:0]  waddr;
      logic [31:0] wval;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        q[$];
   int          last_acc = 0;
   int          last_resp_cyc = 0;
   int          n_resp = 0;
   logic [31:0] last_rdata = 32'h0;
   logic [31:0] last_wval = 32'h0;
   logic        last_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: computes outcome of a request from the access rules alone.
   task automatic push_model(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] ad, input logic [31:0] wd, input int a);
      exp_t        e;
      int          off;
      int          sh;
      logic [31:0] word, b, m;
      e.acc_cyc = a;
      e.rd_cyc  = -1;
      e.wr_cyc  = -1;
      e.wval    = 32'h0;
      e.rdata   = 32'h0;
      e.err     = (sz == 2'd3) || (sz == 2'd1 && ad % 2 != 0) ||
                  (sz == 2'd2 && ad % 4 != 0) || (ad >= 32'd1024);
      e.waddr   = ad[9:2];
      word      = ref_mem[ad[9:2]];
      off       = int'(ad % 4);
      if (e.err) begin
         e.resp_cyc = a;
      end else if (!w) begin
         e.rd_cyc   = a;
         e.resp_cyc = a + 1;
         if (sz == 2'd0) begin
            sh = (3 - off) * 8;
            b  = (word >> sh) & 32'hFF;
            if (sg && b >= 32'd128) b = b | 32'hFFFFFF00;
         end else if (sz == 2'd1) begin
            sh = (2 - off) * 8;
            b  = (word >> sh) & 32'hFFFF;
            if (sg && b >= 32'd32768) b = b | 32'hFFFF0000;
         end else begin
            b = word;
         end
         e.rdata = b;
      end else if (sz == 2'd2) begin
         e.wr_cyc   = a;
         e.resp_cyc = a + 1;
         e.wval     = wd;
         ref_mem[ad[9:2]] = wd;
      end else begin
         e.rd_cyc   = a;
         e.wr_cyc   = a + 1;
         e.resp_cyc = a + 2;
         sh   = (sz == 2'd0) ? (3 - off) * 8 : (2 - off) * 8;
         m    = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
         e.wval = (word & ~m) | ((wd << sh) & m);
         ref_mem[ad[9:2]] = e.wval;
      end
      q.push_back(e);
   endtask

   // Cycle-by-cycle comparison against the head expectation.
   always @(negedge clk) begin
      exp_t h;
      logic e_rd, e_wr, e_resp, busy;
      e_rd = 1'b0; e_wr = 1'b0; e_resp = 1'b0; busy = 1'b0;
      h = '{default: 0};
      if (q.size() > 0) begin
         h      = q[0];
         e_rd   = (h.rd_cyc == cyc);
         e_wr   = (h.wr_cyc == cyc);
         e_resp = (h.resp_cyc == cyc);
         busy   = (cyc >= h.acc_cyc);
      end
      check("req_ready", {31'h0, bus.req_ready}, {31'h0, !busy});
      check("rd_en", {31'h0, bus.mem_read_en_data}, {31'h0, e_rd});
      check("wr_en", {31'h0, bus.mem_write_en_data}, {31'h0, e_wr});
      check("resp_valid", {31'h0, bus.resp_valid}, {31'h0, e_resp});
      check("wval", bus.mem_write_val_data, e_wr ? h.wval : 32'h0);
      if (e_rd || e_wr) check("mem_addr", {24'h0, bus.mem_addr_data}, {24'h0, h.waddr});
      if (e_wr) last_wval = bus.mem_write_val_data;
      if (e_resp) begin
         check("resp_err", {31'h0, bus.resp_err}, {31'h0, h.err});
         check("resp_rdata", bus.resp_rdata, h.rdata);
         last_rdata    = bus.resp_rdata;
         last_err      = bus.resp_err;
         last_resp_cyc = cyc;
         n_resp++;
         void'(q.pop_front());
      end
   end

   // Called at a negedge; returns at the negedge just after the accept edge with req_valid still high.
   task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd);
      int n = 0;
      bus.req_write  = w;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = ad;
      bus.req_wdata  = wd;
      bus.req_valid  = 1'b1;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.req_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready stayed %b, required 1", bus.req_ready);
      end else begin
         last_acc = cyc + 1;
         push_model(w, sz, sg, ad, wd, cyc + 1);
         $display("txn cyc=%0d write=%0d size=%0d signed=%0d addr=%08h wdata=%08h",
                  cyc + 1, w, sz, sg, ad, wd);
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      bus.req_valid = 1'b0;
      while (q.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout: %0d responses outstanding, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic txn(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd);
      do_req(w, sz, sg, ad, wd);
      wait_done();
   endtask

   logic [31:0] err_addr [5];
   logic [1:0]  err_size [5];
   logic        err_wr   [5];
   int          acc [3];
   int          resp_before;
   logic [31:0] saved;

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_size   = 2'b10;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h10;
      bus.req_wdata  = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
      check("rst_rdata", bus.resp_rdata, 32'h0);
      check("rst_err", {31'h0, bus.resp_err}, 32'h0);
      check("rst_addr", {24'h0, bus.mem_addr_data}, 32'h0);
      bus.req_valid = 1'b0;
      mem_clr = 1'b0;
      reset   = 1'b0;
      @(negedge clk);

      txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
      check("lat_word_store", 32'(last_resp_cyc - last_acc + 1), 32'd2);
      txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      check("lit_load_word", last_rdata, 32'hDEADBEEF);
      check("lat_load", 32'(last_resp_cyc - last_acc + 1), 32'd2);
      txn(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
      txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000A5);
      check("lit_byte_merge", last_wval, 32'h11A53344);
      check("lat_sub_store", 32'(last_resp_cyc - last_acc + 1), 32'd3);
      check("lit_mem4", mem[4], 32'h11A53344);
      txn(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
      check("lit_lb_signed", last_rdata, 32'hFFFFFFA5);
      txn(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
      check("lit_lb_unsigned", last_rdata, 32'h000000A5);
      txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
      check("lit_lh_signed", last_rdata, 32'h00003344);
      txn(1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF8001);
      check("lit_half_merge", last_wval, 32'h11A58001);
      txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
      check("lit_lh_neg", last_rdata, 32'hFFFF8001);
      txn(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
      txn(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
      check("lit_lb_off3", last_rdata, 32'h00000001);
      txn(1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
      txn(1'b0, 2'd2, 1'b1, 32'h10, 32'h0);
      check("lit_lw_signed", last_rdata, 32'h11A58001);

      err_addr = '{32'h13, 32'h400, 32'h10, 32'h12, 32'h400};
      err_size = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
      err_wr   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         txn(err_wr[i], err_size[i], 1'b0, err_addr[i], 32'h12345678);
         check("lit_err", {31'h0, last_err}, 32'h1);
         check("lit_err_rdata", last_rdata, 32'h0);
         check("lat_err", 32'(last_resp_cyc - last_acc + 1), 32'd1);
      end

      txn(1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFEF00D);
      txn(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
      check("lit_last_word", last_rdata, 32'hCAFEF00D);

      saved = ref_mem[4];
      do_req(1'b1, 2'd0, 1'b0, 32'h10, 32'h0000005A);
      bus.req_valid = 1'b0;
      check("pre_rst_rd_en", {31'h0, bus.mem_read_en_data}, 32'h1);
      #2 reset = 1'b1;
      #1;
      check("async_rd_en", {31'h0, bus.mem_read_en_data}, 32'h0);
      check("async_wr_en", {31'h0, bus.mem_write_en_data}, 32'h0);
      check("async_ready", {31'h0, bus.req_ready}, 32'h1);
      check("async_resp", {31'h0, bus.resp_valid}, 32'h0);
      q.delete();
      ref_mem[4] = saved;
      #1 reset = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_mem_kept", mem[4], 32'h11A58001);

      resp_before = n_resp;
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      acc[0] = last_acc;
      do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
      acc[1] = last_acc;
      do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
      acc[2] = last_acc;
      wait_done();
      check("spacing01", 32'(acc[1] - acc[0]), 32'd3);
      check("spacing12", 32'(acc[2] - acc[1]), 32'd3);
      check("queued_resps", 32'(n_resp - resp_before), 32'd3);
      check("lit_queued_last", last_rdata, 32'hCAFEF00D);
      check("mem_255", mem[255], ref_mem[255]);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
